pc_redirect_ctrl: RTL and testbench

Fetch-side program counter and redirect controller for the five-stage pipeline. Holds the fetch PC and advances it by 4 each cycle. Applies jump targets (j/jal from ID), register-jump targets (jr from ID) and taken-branch targets (from EX) in priority order, and raises the IF/ID and ID/EX flush signals. A redirect that arrives while fetch is stalled is parked in a pending register and applied when the stall releases.

---
 rtl/pc_redirect_ctrl.sv | 126 ++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC register with prioritised branch/jr/jump redirect,
// stall-time parking of redirects and IF/ID, ID/EX flush generation.
`default_nettype none

module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_address_i,
  input  logic        jr_valid_i,
  input  logic [31:0] jr_address_i,
  input  logic        jump_valid_i,
  input  logic [31:0] jump_address_i,
  output logic [31:0] pc_out_o,
  output logic [31:0] pc_add_result_o,
  output logic        flush_if_o,
  output logic        flush_id_o,
  output logic        pending_o,
  output logic        align_err_o,
  output logic [15:0] redirect_count_o
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_br_q, pend_br_d;
  logic        align_q, align_d;
  logic [15:0] cnt_q, cnt_d;

  logic        req_any;
  logic [31:0] req_tgt;
  logic        apply;
  logic [31:0] app_tgt;
  logic        app_br;

  // A branch belongs to the older instruction, so it wins over anything in ID.
  assign req_any = branch_taken_i | jr_valid_i | jump_valid_i;
  assign req_tgt = branch_taken_i ? branch_address_i :
                   jr_valid_i     ? jr_address_i     : jump_address_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_br_d  = pend_br_q;
    align_d    = align_q;
    cnt_d      = cnt_q;
    apply      = 1'b0;
    app_tgt    = pend_tgt_q;
    app_br     = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (req_any) begin
          if (stall_i) begin
            pend_tgt_d = req_tgt;
            pend_br_d  = branch_taken_i;
            state_d    = ST_PENDING;
          end else begin
            apply   = 1'b1;
            app_tgt = req_tgt;
            app_br  = branch_taken_i;
          end
        end else if (!stall_i) begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_PENDING: begin
        // ID-stage requests here are duplicates of the held instruction or wrong-path.
        if (stall_i) begin
          if (branch_taken_i) begin
            pend_tgt_d = branch_address_i;
            pend_br_d  = 1'b1;
          end
        end else begin
          apply   = 1'b1;
          app_tgt = branch_taken_i ? branch_address_i : pend_tgt_q;
          app_br  = branch_taken_i | pend_br_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (apply) begin
      pc_d = {app_tgt[31:2], 2'b00};
      if (app_tgt[1:0] != 2'b00) align_d = 1'b1;
      if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pend_tgt_q <= 32'h0000_0000;
      pend_br_q  <= 1'b0;
      align_q    <= 1'b0;
      cnt_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_br_q  <= pend_br_d;
      align_q    <= align_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc_out_o         = pc_q;
  assign pc_add_result_o  = pc_q + 32'd4;
  assign flush_if_o       = apply & ~reset_i;
  assign flush_id_o       = apply & app_br & ~reset_i;
  assign pending_o        = (state_q == ST_PENDING);
  assign align_err_o      = align_q;
  assign redirect_count_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl.
`default_nettype none

module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_address_i;
  logic        jr_valid_i;
  logic [31:0] jr_address_i;
  logic        jump_valid_i;
  logic [31:0] jump_address_i;
  logic [31:0] pc_out_o;
  logic [31:0] pc_add_result_o;
  logic        flush_if_o;
  logic        flush_id_o;
  logic        pending_o;
  logic        align_err_o;
  logic [15:0] redirect_count_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.RESET_PC(32'h0040_0000)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .stall_i          (stall_i),
    .branch_taken_i   (branch_taken_i),
    .branch_address_i (branch_address_i),
    .jr_valid_i       (jr_valid_i),
    .jr_address_i     (jr_address_i),
    .jump_valid_i     (jump_valid_i),
    .jump_address_i   (jump_address_i),
    .pc_out_o         (pc_out_o),
    .pc_add_result_o  (pc_add_result_o),
    .flush_if_o       (flush_if_o),
    .flush_id_o       (flush_id_o),
    .pending_o        (pending_o),
    .align_err_o      (align_err_o),
    .redirect_count_o (redirect_count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, then let combinational outputs settle.
  task automatic drive(input logic st, input logic bt, input logic [31:0] ba,
                       input logic jr, input logic [31:0] ja_r,
                       input logic jv, input logic [31:0] ja);
    stall_i = st; branch_taken_i = bt; branch_address_i = ba;
    jr_valid_i = jr; jr_address_i = ja_r; jump_valid_i = jv; jump_address_i = ja;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    check("rst_pc", pc_out_o, 32'h0040_0000);
    check("rst_pend", {31'b0, pending_o}, 0);
    check("rst_align", {31'b0, align_err_o}, 0);
    check("rst_cnt", {16'b0, redirect_count_o}, 0);
    reset_i = 1'b0;

    // Free run
    drive(0, 0, 0, 0, 0, 0, 0);
    check("run0_flif", {31'b0, flush_if_o}, 0);
    check("run0_flid", {31'b0, flush_id_o}, 0);
    check("run0_add", pc_add_result_o, 32'h0040_0004);
    cyc();
    check("run1_pc", pc_out_o, 32'h0040_0004);
    cyc();
    check("run2_pc", pc_out_o, 32'h0040_0008);

    // Jump at 0x00400008
    drive(0, 0, 0, 0, 0, 1, 32'h0040_0100);
    check("j_flif", {31'b0, flush_if_o}, 1);
    check("j_flid", {31'b0, flush_id_o}, 0);
    cyc();
    check("j_pc", pc_out_o, 32'h0040_0100);
    check("j_cnt", {16'b0, redirect_count_o}, 1);

    // Branch beats same-cycle jump
    drive(0, 1, 32'h0040_0200, 0, 0, 1, 32'h0040_0100);
    check("bj_flif", {31'b0, flush_if_o}, 1);
    check("bj_flid", {31'b0, flush_id_o}, 1);
    cyc();
    check("bj_pc", pc_out_o, 32'h0040_0200);
    check("bj_cnt", {16'b0, redirect_count_o}, 2);

    // Stalled jump parked, overwritten by stalled branch
    drive(1, 0, 0, 0, 0, 1, 32'h0040_0300);
    check("s1_flif", {31'b0, flush_if_o}, 0);
    cyc();
    check("s1_pc", pc_out_o, 32'h0040_0200);
    check("s1_pend", {31'b0, pending_o}, 1);
    drive(1, 1, 32'h0040_0400, 0, 0, 0, 0);
    check("s2_flif", {31'b0, flush_if_o}, 0);
    check("s2_flid", {31'b0, flush_id_o}, 0);
    cyc();
    check("s2_pc", pc_out_o, 32'h0040_0200);
    drive(1, 0, 0, 0, 0, 1, 32'h0040_0700);
    cyc();
    check("s3_pc", pc_out_o, 32'h0040_0200);
    check("s3_pend", {31'b0, pending_o}, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rel_flif", {31'b0, flush_if_o}, 1);
    check("rel_flid", {31'b0, flush_id_o}, 1);
    cyc();
    check("rel_pc", pc_out_o, 32'h0040_0400);
    check("rel_pend", {31'b0, pending_o}, 0);
    check("rel_cnt", {16'b0, redirect_count_o}, 3);

    // Parked jr keeps jump-kind flushes on release
    drive(1, 0, 0, 1, 32'h0040_0500, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 32'h0040_0900);
    check("pjr_flif", {31'b0, flush_if_o}, 1);
    check("pjr_flid", {31'b0, flush_id_o}, 0);
    cyc();
    check("pjr_pc", pc_out_o, 32'h0040_0500);
    check("pjr_cnt", {16'b0, redirect_count_o}, 4);

    // 32-bit wrap
    drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    cyc();
    check("wr_pc", pc_out_o, 32'hFFFF_FFFC);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("wr_add", pc_add_result_o, 32'h0000_0000);
    cyc();
    check("wr_pc0", pc_out_o, 32'h0000_0000);

    // Misaligned jr target
    check("al_pre", {31'b0, align_err_o}, 0);
    drive(0, 0, 0, 1, 32'h0040_0013, 0, 0);
    cyc();
    check("al_pc", pc_out_o, 32'h0040_0010);
    check("al_err", {31'b0, align_err_o}, 1);
    check("al_cnt", {16'b0, redirect_count_o}, 6);
    drive(0, 0, 0, 0, 0, 0, 0);
    cyc();
    check("al_pc2", pc_out_o, 32'h0040_0014);
    check("al_sticky", {31'b0, align_err_o}, 1);

    // Reset drops a parked redirect
    drive(1, 1, 32'h0040_0800, 0, 0, 0, 0);
    cyc();
    check("rp_pend", {31'b0, pending_o}, 1);
    reset_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rp_flif", {31'b0, flush_if_o}, 0);
    check("rp_flid", {31'b0, flush_id_o}, 0);
    cyc();
    check("rp_pc", pc_out_o, 32'h0040_0000);
    check("rp_pend0", {31'b0, pending_o}, 0);
    check("rp_cnt", {16'b0, redirect_count_o}, 0);
    check("rp_align", {31'b0, align_err_o}, 0);
    reset_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rp_noflush", {31'b0, flush_if_o}, 0);
    cyc();
    check("rp_run", pc_out_o, 32'h0040_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
